// File: rtl/multi_cycle_control.sv
// multi_cycle_control: FSM sequencer for the multi-cycle MIPS-subset datapath.
// Steps fetch, decode, execute, memory and write-back and drives every
// datapath control input. Outputs are a Moore decode of the state, except:
// PCWr in BRANCH follows zero, run gates FETCH, and reset forces all outputs low.
module multi_cycle_control #(
   parameter bit FETCH_ONLY_HOLD = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   output logic       PCWr,
   output logic       Iord,
   output logic       MemWrite,
   output logic       MemRead,
   output logic       IRwrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] Operation_ALU,
   output logic [1:0] PCSource,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RTWB   = 4'd7,
      BRANCH = 4'd8,
      JUMP   = 4'd9,
      ADDIEX = 4'd10,
      ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   state_t     state_q;
   logic       fetch_hold;
   logic [2:0] rt_op;
   logic       rt_ok;

   assign fetch_hold = FETCH_ONLY_HOLD && !run;

   // Decode the R-type funct field into an ALU operation and a legality flag.
   always_comb begin
      rt_op = 3'b000;
      rt_ok = 1'b1;
      case (funct)
         6'h20:   rt_op = 3'b000;
         6'h22:   rt_op = 3'b001;
         6'h24:   rt_op = 3'b010;
         6'h25:   rt_op = 3'b011;
         6'h26:   rt_op = 3'b100;
         default: rt_ok = 1'b0;
      endcase
   end

   // State register: sequences each instruction and returns to FETCH.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
      end else begin
         case (state_q)
            FETCH:  if (!fetch_hold) state_q <= DECODE;
            DECODE: begin
               case (opcode)
                  OP_RTYPE:     state_q <= EXEC;
                  OP_LW, OP_SW: state_q <= MEMADR;
                  OP_BEQ:       state_q <= BRANCH;
                  OP_J:         state_q <= JUMP;
                  OP_ADDI:      state_q <= ADDIEX;
                  default:      state_q <= FETCH;
               endcase
            end
            MEMADR: state_q <= (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_q <= MEMWB;
            EXEC:   state_q <= RTWB;
            ADDIEX: state_q <= ADDIWB;
            default: state_q <= FETCH;
         endcase
      end
   end

   // Control output decode from the current state; reset silences everything.
   always_comb begin
      PCWr          = 1'b0;
      Iord          = 1'b0;
      MemWrite      = 1'b0;
      MemRead       = 1'b0;
      IRwrite       = 1'b0;
      MemtoReg      = 1'b0;
      RegWrite      = 1'b0;
      RegDst        = 1'b0;
      ALUSrcA       = 1'b0;
      ALUSrcB       = 2'b00;
      Operation_ALU = 3'b000;
      PCSource      = 2'b00;
      illegal       = 1'b0;
      state         = '0;
      if (!reset) begin
         state = state_q;
         case (state_q)
            FETCH: begin
               if (!fetch_hold) begin
                  MemRead = 1'b1;
                  IRwrite = 1'b1;
                  ALUSrcB = 2'b01;
                  PCWr    = 1'b1;
               end
            end
            DECODE: begin
               ALUSrcB = 2'b11;
               case (opcode)
                  OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegal = 1'b0;
                  default: illegal = 1'b1;
               endcase
            end
            MEMADR: begin
               ALUSrcA       = 1'b1;
               ALUSrcB       = 2'b10;
               Operation_ALU = (opcode == OP_LW) ? 3'b101 : 3'b110;
            end
            MEMRD: begin
               MemRead = 1'b1;
               Iord    = 1'b1;
            end
            MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            MEMWR: begin
               MemWrite = 1'b1;
               Iord     = 1'b1;
            end
            EXEC: begin
               ALUSrcA       = 1'b1;
               Operation_ALU = rt_op;
               illegal       = !rt_ok;
            end
            RTWB: begin
               RegDst   = 1'b1;
               RegWrite = rt_ok;
            end
            BRANCH: begin
               ALUSrcA       = 1'b1;
               Operation_ALU = 3'b111;
               PCSource      = 2'b01;
               PCWr          = zero;
            end
            JUMP: begin
               PCSource = 2'b10;
               PCWr     = 1'b1;
            end
            ADDIEX: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            ADDIWB: RegWrite = 1'b1;
            default: state = state_q;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: expected per-cycle output vectors are
// queued as each instruction is set up and compared cycle by cycle.
module tb_multi_cycle_control;

   logic       clk = 1'b0;
   logic       reset, run, zero;
   logic [5:0] opcode, funct;
   logic       PCWr, Iord, MemWrite, MemRead, IRwrite, MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [2:0] Operation_ALU;
   logic [3:0] state;
   logic       illegal;

   multi_cycle_control #(.FETCH_ONLY_HOLD(1'b1)) dut (
      .clk(clk), .reset(reset), .run(run), .opcode(opcode), .funct(funct), .zero(zero),
      .PCWr(PCWr), .Iord(Iord), .MemWrite(MemWrite), .MemRead(MemRead), .IRwrite(IRwrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .Operation_ALU(Operation_ALU), .PCSource(PCSource),
      .state(state), .illegal(illegal)
   );

   always #5 clk = ~clk;

   // {state, PCWr, Iord, MemWrite, MemRead, IRwrite, MemtoReg, RegWrite, RegDst, ALUSrcA,
   //  ALUSrcB, Operation_ALU, PCSource, illegal}
   logic [20:0] obs;
   assign obs = {state, PCWr, Iord, MemWrite, MemRead, IRwrite, MemtoReg, RegWrite, RegDst,
                 ALUSrcA, ALUSrcB, Operation_ALU, PCSource, illegal};

   typedef struct {
      string       tag;
      logic [20:0] vec;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [20:0] v(input logic [3:0] st, input logic [8:0] ctl,
                                     input logic [1:0] asb, input logic [2:0] op,
                                     input logic [1:0] pcs, input logic ill);
      return {st, ctl, asb, op, pcs, ill};
   endfunction

   task automatic push(input string tag, input logic [20:0] vec);
      exp_t e;
      e.tag = tag;
      e.vec = vec;
      sb.push_back(e);
   endtask

   // Compare one cycle at the falling edge, then advance past the next rising edge.
   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         assert (obs === e.vec) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
         end
         @(posedge clk);
         #1;
      end
   endtask

   localparam logic [8:0] C_FETCH  = 9'b100110000;
   localparam logic [8:0] C_NONE   = 9'b000000000;
   localparam logic [8:0] C_ASA    = 9'b000000001;
   localparam logic [8:0] C_RTWB   = 9'b000000110;
   localparam logic [8:0] C_RTBAD  = 9'b000000010;
   localparam logic [8:0] C_MEMRD  = 9'b010100000;
   localparam logic [8:0] C_MEMWB  = 9'b000001100;
   localparam logic [8:0] C_MEMWR  = 9'b011000000;
   localparam logic [8:0] C_BRT    = 9'b100000001;
   localparam logic [8:0] C_JUMP   = 9'b100000000;
   localparam logic [8:0] C_ADDIWB = 9'b000000100;

   logic [20:0] fetch_v, decode_v, hold_v;
   logic [5:0]  rt_funct [5];
   logic [2:0]  rt_op    [5];

   initial begin
      fetch_v  = v(4'd0, C_FETCH, 2'b01, 3'b000, 2'b00, 1'b0);
      decode_v = v(4'd1, C_NONE, 2'b11, 3'b000, 2'b00, 1'b0);
      hold_v   = v(4'd0, C_NONE, 2'b00, 3'b000, 2'b00, 1'b0);
      rt_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
      rt_op    = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

      reset = 1'b1; run = 1'b1; zero = 1'b0; opcode = 6'h00; funct = 6'h20;
      @(posedge clk);
      #1;
      push("reset_outputs", hold_v);
      drain();
      reset = 1'b0;

      // R-type, each supported funct
      for (int i = 0; i < 5; i++) begin
         opcode = 6'h00; funct = rt_funct[i];
         push("rt_fetch", fetch_v);
         push("rt_decode", decode_v);
         push("rt_exec", v(4'd6, C_ASA, 2'b00, rt_op[i], 2'b00, 1'b0));
         push("rt_wb", v(4'd7, C_RTWB, 2'b00, 3'b000, 2'b00, 1'b0));
         drain();
      end

      // lw
      opcode = 6'h23;
      push("lw_fetch", fetch_v);
      push("lw_decode", decode_v);
      push("lw_memadr", v(4'd2, C_ASA, 2'b10, 3'b101, 2'b00, 1'b0));
      push("lw_memrd", v(4'd3, C_MEMRD, 2'b00, 3'b000, 2'b00, 1'b0));
      push("lw_memwb", v(4'd4, C_MEMWB, 2'b00, 3'b000, 2'b00, 1'b0));
      drain();

      // sw
      opcode = 6'h2B;
      push("sw_fetch", fetch_v);
      push("sw_decode", decode_v);
      push("sw_memadr", v(4'd2, C_ASA, 2'b10, 3'b110, 2'b00, 1'b0));
      push("sw_memwr", v(4'd5, C_MEMWR, 2'b00, 3'b000, 2'b00, 1'b0));
      drain();

      // beq taken, then not taken
      opcode = 6'h04; zero = 1'b1;
      push("beq_t_fetch", fetch_v);
      push("beq_t_decode", decode_v);
      push("beq_t_branch", v(4'd8, C_BRT, 2'b00, 3'b111, 2'b01, 1'b0));
      drain();
      zero = 1'b0;
      push("beq_n_fetch", fetch_v);
      push("beq_n_decode", decode_v);
      push("beq_n_branch", v(4'd8, C_ASA, 2'b00, 3'b111, 2'b01, 1'b0));
      drain();

      // j
      opcode = 6'h02;
      push("j_fetch", fetch_v);
      push("j_decode", decode_v);
      push("j_jump", v(4'd9, C_JUMP, 2'b00, 3'b000, 2'b10, 1'b0));
      drain();

      // addi
      opcode = 6'h08;
      push("addi_fetch", fetch_v);
      push("addi_decode", decode_v);
      push("addi_ex", v(4'd10, C_ASA, 2'b10, 3'b000, 2'b00, 1'b0));
      push("addi_wb", v(4'd11, C_ADDIWB, 2'b00, 3'b000, 2'b00, 1'b0));
      drain();

      // illegal opcode
      opcode = 6'h3F;
      push("ill_op_fetch", fetch_v);
      push("ill_op_decode", v(4'd1, C_NONE, 2'b11, 3'b000, 2'b00, 1'b1));
      drain();

      // illegal funct
      opcode = 6'h00; funct = 6'h00;
      push("ill_fn_fetch", fetch_v);
      push("ill_fn_decode", decode_v);
      push("ill_fn_exec", v(4'd6, C_ASA, 2'b00, 3'b000, 2'b00, 1'b1));
      push("ill_fn_wb", v(4'd7, C_RTBAD, 2'b00, 3'b000, 2'b00, 1'b0));
      drain();

      // run low parks in FETCH
      run = 1'b0;
      for (int i = 0; i < 10; i++) push("run_hold", hold_v);
      drain();
      run = 1'b1;

      // run dropped mid-instruction only takes effect back in FETCH
      opcode = 6'h08;
      push("midrun_fetch", fetch_v);
      drain();
      run = 1'b0;
      push("midrun_decode", decode_v);
      push("midrun_ex", v(4'd10, C_ASA, 2'b10, 3'b000, 2'b00, 1'b0));
      push("midrun_wb", v(4'd11, C_ADDIWB, 2'b00, 3'b000, 2'b00, 1'b0));
      push("midrun_hold", hold_v);
      drain();
      run = 1'b1;

      // reset in MEMRD of lw abandons it
      opcode = 6'h23;
      push("rst_lw_fetch", fetch_v);
      push("rst_lw_decode", decode_v);
      push("rst_lw_memadr", v(4'd2, C_ASA, 2'b10, 3'b101, 2'b00, 1'b0));
      drain();
      reset = 1'b1;
      push("rst_lw_memrd", hold_v);
      drain();
      reset = 1'b0;
      opcode = 6'h02;
      push("post_rst_fetch", fetch_v);
      push("post_rst_decode", decode_v);
      push("post_rst_jump", v(4'd9, C_JUMP, 2'b00, 3'b000, 2'b10, 1'b0));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multi_cycle_control.md
# multi_cycle_control

Finite-state control unit for the multi-cycle MIPS-subset datapath. It replaces the hand-set control switches. It samples the opcode and funct fields held in the instruction register and the ALU zero flag, then sequences fetch, decode, execute, memory and write-back cycles by driving every datapath control input. It sits beside `Datapath_Multi_cycle_Processor` and connects one-to-one to its control ports.

## Interface
- `FETCH_ONLY_HOLD`, default 1: when 1, `run`=0 parks the FSM in FETCH with all write enables low; when 0, `run` is ignored.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-high; takes effect on the rising edge of `clk` (one clock; reset is synchronous and active-high).
- `run` input 1: permits a new instruction fetch; sampled only in FETCH.
- `opcode` input 6: `instruction[31:26]` from the IR.
- `funct` input 6: `instruction[5:0]` from the IR.
- `zero` input 1: ALU zero flag; valid while `Operation_ALU`=111.
- `PCWr`, `Iord`, `MemWrite`, `MemRead`, `IRwrite`, `MemtoReg`, `RegWrite`, `RegDst`, `ALUSrcA` output 1 each: datapath controls.
- `ALUSrcB` output 2: 00 B, 01 const 4, 10 sign-extended immediate, 11 immediate<<2.
- `Operation_ALU` output 3: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 lw-add, 110 sw-add, 111 beq-compare.
- `PCSource` output 2: 00 ALU_out, 01 ALU_out_hold, 10 jump address.
- `state` output 4: current state encoding, for display and debug.
- `illegal` output 1: one-cycle pulse on an unsupported opcode or funct.

## Operation
- Moore decode from `state`. Two exceptions: `PCWr` in BRANCH equals `zero`, and `run` gates FETCH.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RTWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- Any output not listed for a state is 0.
- FETCH: `MemRead`=1, `IRwrite`=1, `ALUSrcB`=01, op 000, `PCSource`=00, `PCWr`=1. If `run`=0 and the hold parameter is 1, every output is 0 and the FSM stays in FETCH. Otherwise next state is DECODE.
- DECODE: `ALUSrcB`=11, op 000, which precomputes the branch target into ALU_out_hold. Next state by opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEMADR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08 → ADDIEX
  - any other opcode → FETCH, with `illegal`=1 in this cycle.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, op 101 for lw or 110 for sw. Next state is MEMRD for lw, MEMWR for sw.
- MEMRD: `MemRead`=1, `Iord`=1 → MEMWB.
- MEMWB: `MemtoReg`=1, `RegWrite`=1, `RegDst`=0 → FETCH.
- MEMWR: `MemWrite`=1, `Iord`=1 → FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00. Op from funct: 0x20→000, 0x22→001, 0x24→010, 0x25→011, 0x26→100. Any other funct gives op 000 and `illegal`=1. Next state is RTWB.
- RTWB: `RegDst`=1, `MemtoReg`=0, `RegWrite`=1 → FETCH. If the funct was unsupported, `RegWrite`=0. The funct is re-decoded from the held IR, which is stable.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, op 111, `PCSource`=01, `PCWr`=`zero` → FETCH.
- JUMP: `PCSource`=10, `PCWr`=1 → FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, op 000 → ADDIWB.
- ADDIWB: `RegDst`=0, `MemtoReg`=0, `RegWrite`=1 → FETCH.
- `opcode` and `funct` are read only in DECODE and later states. IR is written only in FETCH, so they are stable from then on.

## Timing
- On a rising edge with `reset`=1, `state` goes to FETCH.
- While `reset` is high, every output is 0, including `PCWr`, `IRwrite`, `MemRead` and `illegal`. This overrides the FETCH decode.
- If `reset` is asserted mid-instruction, the instruction is abandoned. No `RegWrite` or `MemWrite` is issued in the reset cycle.
- The first fetch happens in the first cycle after `reset` falls with `run`=1.
- Cycles per instruction: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, illegal 2. Each count includes FETCH.
- All datapath holding registers latch every cycle. Each state relies on the value latched in the previous state: ALU_out_hold for BRANCH, RTWB and MEMRD; MDR for MEMWB.
- `run` deasserted mid-instruction has no effect until the FSM returns to FETCH.
- No state is reachable other than 0–11. Encodings 12–15, if ever entered, go to FETCH on the next edge with all outputs 0.

## Test plan
- Reset, then `run`=1, `opcode`=0x00, `funct`=0x20 → state sequence 0,1,6,7,0. `IRwrite`=1 and `PCWr`=1 only in cycle 0. `RegWrite`=1 and `RegDst`=1 only in state 7. `Operation_ALU`=000 in state 6.
- `opcode`=0x23 → sequence 0,1,2,3,4,0. Op 101 in state 2. `Iord`=1 and `MemRead`=1 in state 3. `MemtoReg`=1 and `RegWrite`=1 in state 4.
- `opcode`=0x2B → sequence 0,1,2,5,0. `MemWrite`=1 only in state 5. `RegWrite` is never 1.
- `opcode`=0x04:
  - with `zero`=1 in BRANCH → `PCWr`=1, `PCSource`=01;
  - repeated with `zero`=0 → `PCWr`=0;
  - both cases return to FETCH after 3 cycles.
- `opcode`=0x02 → JUMP with `PCSource`=10 and `PCWr`=1. `opcode`=0x3F → `illegal` pulse in DECODE and return to FETCH. `funct`=0x00 with R-type → `illegal` in EXEC and `RegWrite`=0 in RTWB.
- `run`=0 → FSM holds in FETCH with all outputs 0 for 10 cycles. Assert `reset` in MEMRD of a lw → next state FETCH and no `RegWrite` observed.
